// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MUL    = 3'd1,
    ST_DIV    = 3'd2,
    ST_FINISH = 3'd3,
    ST_DZ     = 3'd4
  } state_e;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mode_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: a radix-2 Booth step on {A,Q,q-1} or a
// restoring-divide step on {R,Q}.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  mode_e              mode,
  input  logic [WIDTH:0]     acc,
  input  logic [WIDTH-1:0]   q,
  input  logic               q_m1,
  input  logic [WIDTH-1:0]   operand,
  output logic [WIDTH:0]     acc_next,
  output logic [WIDTH-1:0]   q_next,
  output logic               q_m1_next
);

  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] booth_sum;
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] trial;

  always_comb begin
    m_ext     = {operand[WIDTH-1], operand};
    booth_sum = acc;
    rem_shift = {acc[WIDTH-1:0], q[WIDTH-1]};
    trial     = rem_shift - {1'b0, operand};
    acc_next  = acc;
    q_next    = q;
    q_m1_next = 1'b0;

    if (mode == MODE_MUL) begin
      case ({q[0], q_m1})
        2'b01:   booth_sum = acc + m_ext;
        2'b10:   booth_sum = acc - m_ext;
        default: booth_sum = acc;
      endcase
      acc_next  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
      q_next    = {booth_sum[0], q[WIDTH-1:1]};
      q_m1_next = q[0];
    end else if (trial[WIDTH]) begin
      // Trial subtraction went negative: keep the shifted remainder.
      acc_next = rem_shift;
      q_next   = {q[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = trial;
      q_next   = {q[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences the shared Booth multiplier / restoring divider for the
// multicycle core and produces Hi/Lo results with their load strobes.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             dzero,
  output logic             hi_write,
  output logic             lo_write,
  output logic [WIDTH-1:0] hi_result,
  output logic [WIDTH-1:0] lo_result
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               q_m1_q, q_m1_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               sign_q_q, sign_q_d;
  logic               sign_r_q, sign_r_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dzero_q, dzero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  mode_e              step_mode;
  logic [WIDTH:0]     step_acc;
  logic [WIDTH-1:0]   step_q;
  logic               step_q_m1;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  assign step_mode = (state_q == ST_DIV) ? MODE_DIV : MODE_MUL;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode      (step_mode),
    .acc       (acc_q),
    .q         (q_q),
    .q_m1      (q_m1_q),
    .operand   (opnd_q),
    .acc_next  (step_acc),
    .q_next    (step_q),
    .q_m1_next (step_q_m1)
  );

  always_comb begin
    mag_a    = op_a[WIDTH-1] ? -op_a : op_a;
    mag_b    = op_b[WIDTH-1] ? -op_b : op_b;
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    q_d      = q_q;
    q_m1_d   = q_m1_q;
    opnd_d   = opnd_q;
    sign_q_d = sign_q_q;
    sign_r_d = sign_r_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dzero_d  = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (mult_start) begin
          opnd_d  = op_a;
          q_d     = op_b;
          acc_d   = '0;
          q_m1_d  = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_MUL;
        end else if (div_start) begin
          // A zero divisor is captured as-is and rejected on the next edge.
          opnd_d   = mag_b;
          q_d      = mag_a;
          acc_d    = '0;
          q_m1_d   = 1'b0;
          sign_q_d = op_a[WIDTH-1] ^ op_b[WIDTH-1];
          sign_r_d = op_a[WIDTH-1];
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_DIV;
        end
      end
      ST_MUL, ST_DIV: begin
        if (state_q == ST_DIV && cnt_q == '0 && opnd_q == '0) begin
          dzero_d = 1'b1;
          state_d = ST_DZ;
        end else if (cnt_q == CNT_W'(WIDTH)) begin
          done_d  = 1'b1;
          state_d = ST_FINISH;
          if (state_q == ST_MUL) begin
            hi_d = acc_q[WIDTH-1:0];
            lo_d = q_q;
          end else begin
            hi_d = sign_r_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            lo_d = sign_q_q ? -q_q : q_q;
          end
        end else begin
          acc_d  = step_acc;
          q_d    = step_q;
          q_m1_d = step_q_m1;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      ST_FINISH, ST_DZ: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      q_m1_q   <= 1'b0;
      opnd_q   <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dzero_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      q_m1_q   <= q_m1_d;
      opnd_q   <= opnd_d;
      sign_q_q <= sign_q_d;
      sign_r_q <= sign_r_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dzero_q  <= dzero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign dzero     = dzero_q;
  assign hi_write  = done_q;
  assign lo_write  = done_q;
  assign hi_result = hi_q;
  assign lo_result = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: products, quotients, divide by zero,
// start arbitration and asynchronous reset, with hand-computed expectations.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          mult_start;
  logic          div_start;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          busy;
  logic          done;
  logic          dzero;
  logic          hi_write;
  logic          lo_write;
  logic [W-1:0]  hi_result;
  logic [W-1:0]  lo_result;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .mult_start(mult_start),
    .div_start (div_start),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .dzero     (dzero),
    .hi_write  (hi_write),
    .lo_write  (lo_write),
    .hi_result (hi_result),
    .lo_result (lo_result)
  );

  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
  endtask

  // Called just after a falling edge; the next rising edge is edge 0.
  task automatic applyStimulus(input logic mul, input logic div,
                               input logic [W-1:0] a, input logic [W-1:0] b);
    mult_start = mul;
    div_start  = div;
    op_a       = a;
    op_b       = b;
    @(negedge clk);
    mult_start = 1'b0;
    div_start  = 1'b0;
    op_a       = $urandom;
    op_b       = $urandom;
    checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
    checkOutput("no_done_at_edge0", {31'd0, done}, 32'd0);
  endtask

  // Walks edges 1..W (optionally pulsing div_start at pulse_edge), then
  // checks the result pulse at edge W+1 and the return to idle at W+2.
  task automatic waitResult(input string tag, input logic [W-1:0] hi,
                            input logic [W-1:0] lo, input int pulse_edge);
    int early = 0;
    int idle  = 0;
    for (int e = 1; e <= W; e++) begin
      div_start = (e == pulse_edge);
      if (e == pulse_edge) op_b = 32'd3;
      @(negedge clk);
      if (done) early++;
      if (!busy) idle++;
    end
    div_start = 1'b0;
    checkOutput({tag, "_early_done"}, early, 0);
    checkOutput({tag, "_busy_gap"}, idle, 0);
    @(negedge clk);
    checkOutput({tag, "_done"}, {29'd0, done, hi_write, lo_write}, 32'd7);
    checkOutput({tag, "_busy_finish"}, {31'd0, busy}, 32'd1);
    checkOutput({tag, "_hi"}, hi_result, hi);
    checkOutput({tag, "_lo"}, lo_result, lo);
    @(negedge clk);
    checkOutput({tag, "_done_end"}, {29'd0, done, hi_write, lo_write}, 32'd0);
    checkOutput({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_hi_held"}, hi_result, hi);
    checkOutput({tag, "_lo_held"}, lo_result, lo);
  endtask

  initial begin
    reset      = 1'b0;
    mult_start = 1'b0;
    div_start  = 1'b0;
    op_a       = '0;
    op_b       = '0;
    #2;
    checkOutput("reset_flags", {27'd0, busy, done, dzero, hi_write, lo_write}, 32'd0);
    checkOutput("reset_hi", hi_result, 32'd0);
    checkOutput("reset_lo", lo_result, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    applyStimulus(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    waitResult("mul_7_m3", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);

    applyStimulus(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
    waitResult("mul_min_min", 32'h4000_0000, 32'h0000_0000, 0);

    applyStimulus(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitResult("mul_m1_m1", 32'h0000_0000, 32'h0000_0001, 0);

    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    waitResult("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);

    applyStimulus(1'b0, 1'b1, 32'd100, 32'd7);
    waitResult("div_100_7", 32'd2, 32'd14, 0);

    applyStimulus(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    waitResult("div_min_m1", 32'd0, 32'h8000_0000, 0);

    // Divide by zero: previous Hi=0, Lo=0x80000000 must survive.
    applyStimulus(1'b0, 1'b1, 32'h0000_1234, 32'd0);
    checkOutput("dz_no_dzero_edge0", {31'd0, dzero}, 32'd0);
    @(negedge clk);
    checkOutput("dz_pulse", {31'd0, dzero}, 32'd1);
    checkOutput("dz_no_done", {29'd0, done, hi_write, lo_write}, 32'd0);
    checkOutput("dz_busy", {31'd0, busy}, 32'd1);
    checkOutput("dz_hi_held", hi_result, 32'd0);
    checkOutput("dz_lo_held", lo_result, 32'h8000_0000);
    @(negedge clk);
    checkOutput("dz_end", {29'd0, busy, dzero, done}, 32'd0);
    checkOutput("dz_lo_after", lo_result, 32'h8000_0000);

    // Both starts together, then a stray div_start at edge 10.
    applyStimulus(1'b1, 1'b1, 32'd5, 32'd6);
    waitResult("mul_wins", 32'd0, 32'd30, 10);
    repeat (3) @(negedge clk);
    checkOutput("no_second_op", {29'd0, busy, done, dzero}, 32'd0);
    checkOutput("no_second_lo", lo_result, 32'd30);

    // Asynchronous reset in the middle of a divide.
    applyStimulus(1'b0, 1'b1, 32'd100, 32'd7);
    repeat (14) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("midreset_flags", {27'd0, busy, done, dzero, hi_write, lo_write}, 32'd0);
    checkOutput("midreset_hi", hi_result, 32'd0);
    checkOutput("midreset_lo", lo_result, 32'd0);
    @(negedge clk);
    checkOutput("midreset_hold", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("after_reset_idle", {29'd0, busy, done, dzero}, 32'd0);

    applyStimulus(1'b1, 1'b0, 32'd3, 32'd4);
    waitResult("mul_3_4", 32'd0, 32'd12, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
